// File: rtl/ic_cpu_bus_router_pkg.sv
// Shared constants for the CPU bus router: target select codes and FSM state encoding.
package ic_pkg;

  localparam logic [1:0] IC_SEL_ROM  = 2'd0;
  localparam logic [1:0] IC_SEL_RAM  = 2'd1;
  localparam logic [1:0] IC_SEL_PER  = 2'd2;
  localparam logic [1:0] IC_SEL_NONE = 2'd3;

  localparam logic [1:0] IC_ST_IDLE     = 2'd0;
  localparam logic [1:0] IC_ST_WAIT_RSP = 2'd1;
  localparam logic [1:0] IC_ST_ERR_RSP  = 2'd2;

  function automatic logic region_hit(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] mask);
    return (addr & mask) == base;
  endfunction

endpackage

// File: rtl/ic_cpu_bus_router_if.sv
// Codebase memory bus: req/gnt request channel and recv/ack response channel.
interface ic_cpu_bus_router_if;
  // A request transfers on a cycle with mem_req && mem_gnt; a response transfers on a
  // cycle with mem_recv && mem_ack. Request fields are stable while mem_req waits for
  // mem_gnt, and mem_recv/mem_error/mem_rdata are held until mem_ack.
  logic        mem_req;
  logic        mem_wen;
  logic [3:0]  mem_strb;
  logic [31:0] mem_wdata;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_recv;
  logic        mem_ack;
  logic        mem_error;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_wen, mem_strb, mem_wdata, mem_addr, mem_ack,
    input  mem_gnt, mem_recv, mem_error, mem_rdata
  );

  modport slave (
    input  mem_req, mem_wen, mem_strb, mem_wdata, mem_addr, mem_ack,
    output mem_gnt, mem_recv, mem_error, mem_rdata
  );
endinterface

// File: rtl/ic_cpu_bus_router_addr_decode.sv
// Combinational region decoder: ROM beats RAM beats peripheral, anything else is unmapped.
module ic_addr_decode
  import ic_pkg::*;
#(
    parameter logic [31:0] R0_BASE = 32'h0000_0000,
    parameter logic [31:0] R0_MASK = 32'hFFFF_F000,
    parameter logic [31:0] R1_BASE = 32'h0001_0000,
    parameter logic [31:0] R1_MASK = 32'hFFFF_0000,
    parameter logic [31:0] R2_BASE = 32'h4000_0000,
    parameter logic [31:0] R2_MASK = 32'hF000_0000
) (
    input  logic [31:0] addr,
    output logic [1:0]  sel
);

    always_comb begin
        if (region_hit(addr, R0_BASE, R0_MASK)) begin
            sel = IC_SEL_ROM;
        end else if (region_hit(addr, R1_BASE, R1_MASK)) begin
            sel = IC_SEL_RAM;
        end else if (region_hit(addr, R2_BASE, R2_MASK)) begin
            sel = IC_SEL_PER;
        end else begin
            sel = IC_SEL_NONE;
        end
    end

endmodule

// File: rtl/ic_cpu_bus_router.sv
// Routes the merged CPU bus to ROM/RAM/peripheral targets, one transaction in flight.
// Build option IC_ROUTER_ROM_WP_EN turns writes into ROM into error responses.
module ic_cpu_bus_router
  import ic_pkg::*;
#(
    parameter logic [31:0] R0_BASE = 32'h0000_0000,
    parameter logic [31:0] R0_MASK = 32'hFFFF_F000,
    parameter logic [31:0] R1_BASE = 32'h0001_0000,
    parameter logic [31:0] R1_MASK = 32'hFFFF_0000,
    parameter logic [31:0] R2_BASE = 32'h4000_0000,
    parameter logic [31:0] R2_MASK = 32'hF000_0000
) (
    input  logic                       g_clk,
    input  logic                       g_reset,
    ic_cpu_bus_router_if.slave         s,
    ic_cpu_bus_router_if.master        m0,
    ic_cpu_bus_router_if.master        m1,
    ic_cpu_bus_router_if.master        m2,
    output logic [1:0]                 dbg_state,
    output logic [1:0]                 dbg_sel
);

    logic [1:0]  state, state_nxt;
    logic [1:0]  sel, sel_nxt;
    logic [1:0]  dec_sel, tgt;
    logic [2:0]  m_gnt, m_recv, m_err, m_req, m_ack;
    logic [31:0] m_rdata [3];
    logic        s_gnt, s_recv, s_err;
    logic [31:0] s_rdata;

    ic_addr_decode #(
        .R0_BASE(R0_BASE), .R0_MASK(R0_MASK),
        .R1_BASE(R1_BASE), .R1_MASK(R1_MASK),
        .R2_BASE(R2_BASE), .R2_MASK(R2_MASK)
    ) u_decode (
        .addr (s.mem_addr),
        .sel  (dec_sel)
    );

    always_comb begin
        tgt = dec_sel;
`ifdef IC_ROUTER_ROM_WP_EN
        if (dec_sel == IC_SEL_ROM && s.mem_wen) tgt = IC_SEL_NONE;
`endif
    end

    assign m_gnt      = {m2.mem_gnt,   m1.mem_gnt,   m0.mem_gnt};
    assign m_recv     = {m2.mem_recv,  m1.mem_recv,  m0.mem_recv};
    assign m_err      = {m2.mem_error, m1.mem_error, m0.mem_error};
    assign m_rdata[0] = m0.mem_rdata;
    assign m_rdata[1] = m1.mem_rdata;
    assign m_rdata[2] = m2.mem_rdata;

    // Outputs are forced idle while reset is held so nothing leaks out mid-reset.
    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        m_req     = '0;
        m_ack     = '0;
        s_gnt     = 1'b0;
        s_recv    = 1'b0;
        s_err     = 1'b0;
        s_rdata   = '0;
        if (!g_reset) begin
            case (state)
                IC_ST_IDLE: begin
                    if (s.mem_req) begin
                        if (tgt == IC_SEL_NONE) begin
                            s_gnt     = 1'b1;
                            state_nxt = IC_ST_ERR_RSP;
                        end else begin
                            for (int i = 0; i < 3; i++) begin
                                if (tgt == i[1:0]) begin
                                    m_req[i] = 1'b1;
                                    s_gnt    = m_gnt[i];
                                    if (m_gnt[i]) begin
                                        sel_nxt   = tgt;
                                        state_nxt = IC_ST_WAIT_RSP;
                                    end
                                end
                            end
                        end
                    end
                end
                IC_ST_WAIT_RSP: begin
                    for (int i = 0; i < 3; i++) begin
                        if (sel == i[1:0]) begin
                            s_recv   = m_recv[i];
                            s_err    = m_err[i];
                            s_rdata  = m_rdata[i];
                            m_ack[i] = s.mem_ack;
                        end
                    end
                    if (s_recv && s.mem_ack) state_nxt = IC_ST_IDLE;
                end
                IC_ST_ERR_RSP: begin
                    s_recv = 1'b1;
                    s_err  = 1'b1;
                    if (s.mem_ack) state_nxt = IC_ST_IDLE;
                end
                default: state_nxt = IC_ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            state <= IC_ST_IDLE;
            sel   <= IC_SEL_ROM;
        end else begin
            state <= state_nxt;
            sel   <= sel_nxt;
        end
    end

    assign s.mem_gnt   = s_gnt;
    assign s.mem_recv  = s_recv;
    assign s.mem_error = s_err;
    assign s.mem_rdata = s_rdata;

    // Request fields are broadcast; only req and ack are steered per target.
    assign m0.mem_req   = m_req[0];
    assign m1.mem_req   = m_req[1];
    assign m2.mem_req   = m_req[2];
    assign m0.mem_ack   = m_ack[0];
    assign m1.mem_ack   = m_ack[1];
    assign m2.mem_ack   = m_ack[2];
    assign m0.mem_wen   = s.mem_wen;
    assign m1.mem_wen   = s.mem_wen;
    assign m2.mem_wen   = s.mem_wen;
    assign m0.mem_strb  = s.mem_strb;
    assign m1.mem_strb  = s.mem_strb;
    assign m2.mem_strb  = s.mem_strb;
    assign m0.mem_wdata = s.mem_wdata;
    assign m1.mem_wdata = s.mem_wdata;
    assign m2.mem_wdata = s.mem_wdata;
    assign m0.mem_addr  = s.mem_addr;
    assign m1.mem_addr  = s.mem_addr;
    assign m2.mem_addr  = s.mem_addr;

    assign dbg_state = state;
    assign dbg_sel   = sel;

endmodule

// File: tb/tb_ic_cpu_bus_router.sv
// Bench for ic_cpu_bus_router: target models, directed scenarios, random traffic,
// and a response scoreboard fed from a behavioural address-map model.
module tb_ic_cpu_bus_router;

  logic       g_clk = 1'b0;
  logic       g_reset;
  logic [1:0] dbg_state;
  logic [1:0] dbg_sel;

  ic_cpu_bus_router_if s_if ();
  ic_cpu_bus_router_if m_if [3] ();

  ic_cpu_bus_router dut (
    .g_clk     (g_clk),
    .g_reset   (g_reset),
    .s         (s_if),
    .m0        (m_if[0]),
    .m1        (m_if[1]),
    .m2        (m_if[2]),
    .dbg_state (dbg_state),
    .dbg_sel   (dbg_sel)
  );

  // ---------------- clock ----------------
  always #5 g_clk = ~g_clk;

`ifdef IC_ROUTER_ROM_WP_EN
  localparam bit ROM_WP = 1'b1;
`else
  localparam bit ROM_WP = 1'b0;
`endif

  int          total = 0;
  int          bad = 0;
  logic [32:0] exp_q[$];
  int          fix_gnt = -1;
  int          fix_rsp = -1;
  logic [2:0]  stray_recv = 3'b000;
  logic [2:0]  m_req_v;
  logic [2:0]  m_ack_v;
  logic [31:0] m_addr_v [3];
  logic [36:0] m_rest_v [3];
  logic [31:0] salt [3];

  // Target k answers with addr ^ salt[k]; RAM salt makes 0x0001_0040 read 0xDEADBEEF.
  initial begin
    salt[0] = 32'h1111_1111;
    salt[1] = 32'hDEAC_BEAF;
    salt[2] = 32'h3333_3333;
  end

  // ---------------- reference model ----------------
  function automatic int model_tgt(input logic [31:0] a, input logic w);
    if ((a & 32'hFFFF_F000) == 32'h0000_0000) return (ROM_WP && w) ? 3 : 0;
    if ((a & 32'hFFFF_0000) == 32'h0001_0000) return 1;
    if ((a & 32'hF000_0000) == 32'h4000_0000) return 2;
    return 3;
  endfunction

  function automatic logic [32:0] model_rsp(input logic [31:0] a, input logic w);
    int t;
    t = model_tgt(a, w);
    if (t == 3) return {1'b1, 32'h0};
    return {a[7:0] == 8'hEE, a ^ salt[t]};
  endfunction

  function automatic int pick(input int f);
    return (f >= 0) ? f : int'($urandom_range(0, 3));
  endfunction

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- target models ----------------
  for (genvar k = 0; k < 3; k++) begin : g_tgt
    logic        bgnt, brecv, berr, abort;
    logic [31:0] brd, baddr;

    assign m_if[k].mem_gnt   = bgnt;
    assign m_if[k].mem_recv  = brecv | stray_recv[k];
    assign m_if[k].mem_error = berr;
    assign m_if[k].mem_rdata = brd;
    assign m_req_v[k]        = m_if[k].mem_req;
    assign m_ack_v[k]        = m_if[k].mem_ack;
    assign m_addr_v[k]       = m_if[k].mem_addr;
    assign m_rest_v[k]       = {m_if[k].mem_wen, m_if[k].mem_strb, m_if[k].mem_wdata};

    initial begin
      bgnt = 1'b0; brecv = 1'b0; berr = 1'b0; brd = '0; baddr = '0; abort = 1'b0;
      forever begin
        @(posedge g_clk); #2;
        if (m_if[k].mem_req && !g_reset) begin
          baddr = m_if[k].mem_addr;
          repeat (pick(fix_gnt)) begin @(posedge g_clk); #2; end
          bgnt = 1'b1;
          @(posedge g_clk); #2;
          bgnt  = 1'b0;
          abort = g_reset;
          repeat (pick(fix_rsp)) begin
            @(posedge g_clk); #2;
            if (g_reset) abort = 1'b1;
          end
          if (!abort) begin
            brecv = 1'b1;
            berr  = (baddr[7:0] == 8'hEE);
            brd   = baddr ^ salt[k];
            do @(negedge g_clk); while (!m_if[k].mem_ack && !g_reset);
            @(posedge g_clk); #2;
            brecv = 1'b0; berr = 1'b0; brd = '0;
          end
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [32:0] e;
    forever begin
      @(negedge g_clk);
      if (g_reset !== 1'b0) continue;
      for (int k = 0; k < 3; k++) begin
        if (m_req_v[k]) begin
          chk("route", k, model_tgt(s_if.mem_addr, s_if.mem_wen));
          chk("bcast_addr", m_addr_v[k], s_if.mem_addr);
          chk("bcast_fields", m_rest_v[k], {s_if.mem_wen, s_if.mem_strb, s_if.mem_wdata});
        end
      end
      if (m_ack_v != 3'b000) begin
        chk("ack_onehot", $countones(m_ack_v), 1);
        chk("ack_mirror", s_if.mem_ack, 1'b1);
      end
      if (s_if.mem_recv && s_if.mem_ack) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rsp_unexpected: actual=%0h required=none", {s_if.mem_error, s_if.mem_rdata});
        end else begin
          e = exp_q.pop_front();
          chk("rsp", {s_if.mem_error, s_if.mem_rdata}, e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_gnt(output int cyc);
    bit done;
    cyc = 0; done = 1'b0;
    while (!done) begin
      @(negedge g_clk);
      if (s_if.mem_gnt) done = 1'b1;
      else begin
        cyc++;
        if (cyc > 40) begin
          total++; bad++;
          $display("FAIL gnt_timeout: actual=no_gnt required=gnt addr=%0h", s_if.mem_addr);
          done = 1'b1;
        end
      end
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic w, output int gcyc);
    exp_q.push_back(model_rsp(a, w));
    @(posedge g_clk); #1;
    s_if.mem_req   = 1'b1;
    s_if.mem_addr  = a;
    s_if.mem_wen   = w;
    s_if.mem_strb  = 4'($urandom);
    s_if.mem_wdata = $urandom;
    wait_gnt(gcyc);
    @(posedge g_clk); #1;
    s_if.mem_req = 1'b0;
  endtask

  task automatic finish(input logic [31:0] a, input logic w, input int ackdly, output int rcyc);
    bit         done;
    int         t;
    logic [2:0] one;
    rcyc = 0; done = 1'b0;
    while (!done) begin
      @(negedge g_clk);
      if (s_if.mem_recv) done = 1'b1;
      else begin
        rcyc++;
        if (rcyc > 40) begin
          total++; bad++;
          $display("FAIL recv_timeout: actual=no_recv required=recv addr=%0h", a);
          done = 1'b1;
        end
      end
    end
    repeat (ackdly) begin
      @(posedge g_clk);
      @(negedge g_clk);
      chk("recv_held", s_if.mem_recv, 1'b1);
    end
    @(posedge g_clk); #1;
    s_if.mem_ack = 1'b1;
    @(negedge g_clk);
    t = model_tgt(a, w);
    one = (t < 3) ? (3'b001 << t) : 3'b000;
    chk("ack_route", m_ack_v, one);
    @(posedge g_clk); #1;
    s_if.mem_ack = 1'b0;
    @(negedge g_clk);
    chk("recv_drop", s_if.mem_recv, 1'b0);
  endtask

  task automatic do_txn(input logic [31:0] a, input logic w, input int ackdly,
                        output int gcyc, output int rcyc);
    issue(a, w, gcyc);
    finish(a, w, ackdly, rcyc);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_gnt"}, s_if.mem_gnt, 1'b0);
    chk({tag, "_recv"}, s_if.mem_recv, 1'b0);
    chk({tag, "_err"}, s_if.mem_error, 1'b0);
    chk({tag, "_rdata"}, s_if.mem_rdata, 32'h0);
    chk({tag, "_mreq"}, m_req_v, 3'b000);
    chk({tag, "_mack"}, m_ack_v, 3'b000);
    chk({tag, "_state"}, dbg_state, 2'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          g, r, n;
    bit          done;
    logic [31:0] a;
    logic        w;

    g_reset = 1'b1;
    s_if.mem_req = 1'b0; s_if.mem_wen = 1'b0; s_if.mem_strb = '0;
    s_if.mem_wdata = '0; s_if.mem_addr = '0; s_if.mem_ack = 1'b0;
    repeat (3) @(posedge g_clk);
    @(negedge g_clk);
    chk_idle("reset");
    @(posedge g_clk); #1;
    g_reset = 1'b0;
    @(negedge g_clk);
    chk_idle("post_reset");

    // RAM read, target grants on the third cycle
    fix_gnt = 2; fix_rsp = 1;
    do_txn(32'h0001_0040, 1'b0, 1, g, r);
    chk("ram_gnt_cycle", g, 2);

    // unmapped: same-cycle gnt, error on the next cycle, held for 3 cycles
    do_txn(32'h2000_0000, 1'b0, 3, g, r);
    chk("unmapped_gnt_lat", g, 0);
    chk("unmapped_recv_lat", r, 0);

    // back-to-back: peripheral request held during a ROM read
    fix_gnt = 0; fix_rsp = 3;
    exp_q.push_back(model_rsp(32'h0000_0100, 1'b0));
    @(posedge g_clk); #1;
    s_if.mem_req = 1'b1; s_if.mem_addr = 32'h0000_0100; s_if.mem_wen = 1'b0;
    wait_gnt(g);
    @(posedge g_clk); #1;
    s_if.mem_addr = 32'h4000_0004;
    exp_q.push_back(model_rsp(32'h4000_0004, 1'b0));
    n = 0; done = 1'b0;
    while (!done && n < 40) begin
      @(negedge g_clk);
      chk("b2b_stall_gnt", s_if.mem_gnt, 1'b0);
      chk("b2b_stall_m2", m_req_v[2], 1'b0);
      if (s_if.mem_recv) done = 1'b1;
      n++;
    end
    chk("b2b_rom_recv", done, 1'b1);
    @(posedge g_clk); #1;
    s_if.mem_ack = 1'b1;
    @(negedge g_clk);
    chk("b2b_hs_gnt", s_if.mem_gnt, 1'b0);
    chk("b2b_hs_m2", m_req_v[2], 1'b0);
    @(posedge g_clk); #1;
    s_if.mem_ack = 1'b0;
    @(negedge g_clk);
    chk("b2b_m2_after", m_req_v[2], 1'b1);
    chk("b2b_gnt_after", s_if.mem_gnt, 1'b1);
    @(posedge g_clk); #1;
    s_if.mem_req = 1'b0;
    finish(32'h4000_0004, 1'b0, 0, r);

    // stray ROM recv while RAM is selected
    fix_gnt = 0; fix_rsp = 4;
    issue(32'h0001_0100, 1'b0, g);
    stray_recv[0] = 1'b1;
    s_if.mem_ack = 1'b1;
    @(negedge g_clk);
    chk("stray_recv", s_if.mem_recv, 1'b0);
    chk("stray_ack0", m_ack_v[0], 1'b0);
    chk("stray_ack1", m_ack_v[1], 1'b1);
    @(posedge g_clk); #1;
    stray_recv[0] = 1'b0;
    s_if.mem_ack = 1'b0;
    finish(32'h0001_0100, 1'b0, 1, r);

    // ROM write: protected builds answer with an immediate error
    fix_gnt = 1; fix_rsp = 0;
    do_txn(32'h0000_0010, 1'b1, 0, g, r);
    chk("rom_wr_gnt", g, ROM_WP ? 0 : 1);

    // reset in the middle of a RAM transaction, then a normal RAM access
    fix_gnt = 0; fix_rsp = 6;
    issue(32'h0001_0200, 1'b0, g);
    g_reset = 1'b1;
    @(posedge g_clk); #1;
    g_reset = 1'b0;
    void'(exp_q.pop_back());
    @(negedge g_clk);
    chk_idle("rst_mid");
    fix_gnt = -1; fix_rsp = -1;
    do_txn(32'h0001_0300, 1'b0, 1, g, r);

    // random traffic
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 4))
        0:       a = {20'h00000, 12'($urandom)};
        1:       a = {16'h0001, 16'($urandom)};
        2:       a = {4'h4, 28'($urandom)};
        3:       a = {4'h2, 28'($urandom)};
        default: a = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) a[7:0] = 8'hEE;
      w = 1'($urandom);
      do_txn(a, w, int'($urandom_range(0, 3)), g, r);
    end

    repeat (4) @(posedge g_clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    total++;
    bad++;
    $display("FAIL watchdog: actual=running required=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ic_cpu_bus_router.md
Name: ic_cpu_bus_router

Overview:
- Downstream of the two-to-one CPU bus mux: takes its single merged master bus and routes each request to one of three target ports by address: m0 = ROM, m1 = RAM, m2 = peripheral.
- Unmapped addresses are completed internally with an error response.
- Exactly one transaction is in flight; response channel is demultiplexed back from the selected target.
- Uses the codebase req/gnt request and recv/ack response handshakes.

Parameters:
- R0_BASE, 32'h0000_0000, ROM region base.
- R0_MASK, 32'hFFFF_F000, ROM region mask; hit when (addr & R0_MASK) == R0_BASE.
- R1_BASE, 32'h0001_0000, RAM region base.
- R1_MASK, 32'hFFFF_0000, RAM region mask.
- R2_BASE, 32'h4000_0000, peripheral region base.
- R2_MASK, 32'hF000_0000, peripheral region mask.

Ports:
- g_clk in 1: clock.
- g_reset in 1: reset, synchronous, active-high.
- s_mem_req in 1: upstream request.
- s_mem_wen in 1: write enable.
- s_mem_strb in 4: write strobe.
- s_mem_wdata in 32: write data.
- s_mem_addr in 32: address.
- s_mem_gnt out 1: request accepted.
- s_mem_recv out 1: response valid.
- s_mem_ack in 1: response accepted.
- s_mem_error out 1: response error.
- s_mem_rdata out 32: read data.
- mN_mem_req out 1 (N=0,1,2): target request.
- mN_mem_wen/strb/wdata/addr out 1/4/32/32: broadcast copies of the s_* fields.
- mN_mem_gnt in 1: target accept.
- mN_mem_recv in 1: target response valid.
- mN_mem_ack out 1: response accept to target.
- mN_mem_error in 1: target error.
- mN_mem_rdata in 32: target read data.

Behaviour:
- Decode priority: R0 > R1 > R2; no hit = unmapped. Decode is combinational on s_mem_addr.
- State machine:
  - IDLE:
    - s_mem_req && hit Rk: mk_mem_req=1, s_mem_gnt=mk_mem_gnt. On the gnt cycle, sel<=k and go to WAIT_RSP.
    - s_mem_req && unmapped: s_mem_gnt=1 the same cycle, go to ERR_RSP. No mN_mem_req is asserted.
  - WAIT_RSP:
    - All mN_mem_req=0 and s_mem_gnt=0; new requests stall.
    - s_mem_recv=m[sel]_mem_recv; s_mem_error and s_mem_rdata come from m[sel]; m[sel]_mem_ack=s_mem_ack, other acks 0.
    - recv && ack: go to IDLE. A new request is accepted no earlier than the following cycle.
  - ERR_RSP:
    - s_mem_recv=1, s_mem_error=1, s_mem_rdata=0. Held until s_mem_ack, then go to IDLE.
- Request fields pass straight through to all targets (no mux); only req is gated.
- In IDLE, s_mem_req withdrawn before gnt is legal; no state change.
- Unselected mN_mem_recv pulses are ignored; their ack is 0.
- Reset (any state, including mid-transaction): state=IDLE, sel=0, all mN_mem_req=0, s_mem_gnt=0, s_mem_recv=0, s_mem_error=0, s_mem_rdata=0, all mN_mem_ack=0. Any in-flight target transaction is abandoned.
- Outputs in IDLE: s_mem_recv=0, s_mem_error=0, s_mem_rdata=0.
- Latency:
  - Mapped: request-to-gnt is combinational through the target.
  - Unmapped: gnt in the same cycle, error recv in the next cycle.

Optional Feature:
- Macro IC_ROUTER_ROM_WP_EN.
- Defined: a request with s_mem_wen=1 hitting R0 is treated as unmapped (immediate gnt, error response); m0_mem_req is never asserted for writes.
- Undefined: ROM writes are forwarded to m0 like any other access.

Decomposition:
- Shared header/package (ic_pkg): region select encoding IC_SEL_ROM=2'd0, IC_SEL_RAM=2'd1, IC_SEL_PER=2'd2, IC_SEL_NONE=2'd3; state encoding IDLE/WAIT_RSP/ERR_RSP.
- One sub-module, ic_addr_decode: combinational, parameterised by the BASE/MASK pairs, outputs the 2-bit select.

Test Plan:
- Read addr 32'h0001_0040, m1 gnt after 2 cycles, m1 recv rdata=32'hDEADBEEF -> only m1_mem_req high; s_mem_gnt on the 3rd cycle; s_mem_rdata=32'hDEADBEEF, s_mem_error=0; m1_mem_ack mirrors s_mem_ack.
- Access to 32'h2000_0000 (unmapped) -> s_mem_gnt same cycle; next cycle s_mem_recv=1, error=1, rdata=0; held 3 cycles until ack, then IDLE.
- Back-to-back: second request to 32'h4000_0004 asserted during WAIT_RSP of a ROM read -> s_mem_gnt=0 and m2_mem_req=0 until the cycle after the ROM recv&&ack.
- Stray m0_mem_recv=1 while sel=RAM -> s_mem_recv unaffected, m0_mem_ack=0.
- Write to 32'h0000_0010: with IC_ROUTER_ROM_WP_EN -> error response, m0_mem_req never high; without it -> forwarded to m0.
- g_reset asserted in WAIT_RSP -> next cycle all outputs 0, state IDLE; a following RAM request completes normally.
